instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/arm_pkg.sv | 35 +++
 rtl/fetch_buffer.sv | 82 ++++++++
 rtl/instruction_fetch.sv | 143 ++++++++++++++
 tb/tb_instruction_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the fetch front end and decoder: fetch FSM states,
// architectural constants and condition codes.
package arm_pkg;

    typedef enum logic [1:0] {
        FetchIdle,
        FetchReq,
        FetchDrop
    } fetch_state_t;

    localparam logic [3:0]  PC_REG_IDX = 4'd15;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ENTRY_W    = 64;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {instruction, pc} entries with a registered head so the
// decoder-facing outputs come straight from flops.
module fetch_buffer
    import arm_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [ENTRY_W-1:0]           i_push_data,
    input  logic                         i_pop,
    output logic [ENTRY_W-1:0]           o_head,
    output logic                         o_valid,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [ENTRY_W-1:0] r_head;
    logic               r_head_valid;

    logic               w_pop;
    logic               w_push;
    logic [CNT_W-1:0]   w_after_pop;
    logic [CNT_W-1:0]   w_count_next;
    logic [PTR_W-1:0]   w_rd_next;
    logic [ENTRY_W-1:0] w_head_next;

    assign w_pop        = i_pop & ~i_flush & (r_count != '0);
    assign w_push       = i_push & ~i_flush & ((r_count != CNT_W'(DEPTH)) | w_pop);
    assign w_after_pop  = r_count - CNT_W'(w_pop);
    assign w_count_next = w_after_pop + CNT_W'(w_push);
    assign w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
    // An entry pushed into an otherwise empty buffer becomes the head directly.
    assign w_head_next  = (w_after_pop == '0) ? i_push_data : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head       <= '0;
            r_head_valid <= 1'b0;
        end else if (i_flush) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
        end else begin
            r_rd_ptr     <= w_rd_next;
            r_wr_ptr     <= r_wr_ptr + PTR_W'(w_push);
            r_count      <= w_count_next;
            r_head_valid <= (w_count_next != '0);
            // Head keeps its last contents once the buffer drains.
            if (w_count_next != '0) begin
                r_head <= w_head_next;
            end
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_head_valid;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single-outstanding memory requester feeding a small
// prefetch buffer, with PC redirect and stale-response discard.
module instruction_fetch
    import arm_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH        = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        pc_load,
    input  logic [31:0] pc_new
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        w_fetch_pc_next;
    logic [31:0]        r_mem_addr;
    logic [31:0]        w_mem_addr_next;
    logic               r_mem_req;
    logic               w_mem_req_next;

    logic               w_push;
    logic               w_pop;
    logic               w_space;
    logic               w_buf_full;
    logic               w_buf_empty;
    logic               w_head_valid;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]   w_buf_count;
    logic [CNT_W-1:0]   w_occ_next;
    logic [31:0]        w_pc_inc;
    logic [31:0]        w_target;

    assign w_pc_inc = r_fetch_pc + 32'(WORD_BYTES);
    assign w_target = word_align(pc_new);

    // A redirect flushes the buffer, so it suppresses both pop and push.
    assign w_pop  = ins_ready & ~w_buf_empty & ~pc_load;
    assign w_push = (r_state == FetchReq) & mem_ready & ~pc_load & (~w_buf_full | w_pop);

    // Issue only if the buffer still has room once this cycle's traffic settles.
    assign w_occ_next = pc_load ? '0 : (w_buf_count + CNT_W'(w_push) - CNT_W'(w_pop));
    assign w_space    = (w_occ_next < CNT_W'(DEPTH));

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        unique case (r_state)
            FetchIdle: begin
                if (pc_load) begin
                    w_fetch_pc_next = w_target;
                end else if (w_space) begin
                    w_state_next    = FetchReq;
                    w_mem_req_next  = 1'b1;
                    w_mem_addr_next = r_fetch_pc;
                end
            end
            FetchReq: begin
                if (pc_load) begin
                    w_fetch_pc_next = w_target;
                    if (mem_ready) begin
                        w_state_next   = FetchIdle;
                        w_mem_req_next = 1'b0;
                    end else begin
                        w_state_next = FetchDrop;
                    end
                end else if (mem_ready) begin
                    w_fetch_pc_next = w_pc_inc;
                    if (w_space) begin
                        w_mem_addr_next = w_pc_inc;
                    end else begin
                        w_state_next   = FetchIdle;
                        w_mem_req_next = 1'b0;
                    end
                end
            end
            FetchDrop: begin
                if (pc_load) begin
                    w_fetch_pc_next = w_target;
                end
                if (mem_ready) begin
                    w_state_next   = FetchIdle;
                    w_mem_req_next = 1'b0;
                end
            end
            default: begin
                w_state_next   = FetchIdle;
                w_mem_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FetchIdle;
            r_fetch_pc <= RESET_VECTOR;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (pc_load),
        .i_push      (w_push),
        .i_push_data ({mem_rdata, r_mem_addr}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_valid     (w_head_valid),
        .o_full      (w_buf_full),
        .o_empty     (w_buf_empty),
        .o_count     (w_buf_count)
    );

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign ins       = w_head[63:32];
    assign ins_pc    = w_head[31:0];
    assign ins_valid = w_head_valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized checks of instruction_fetch against a program-order
// stream model and a fixed address->word memory image.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic        pc_load;
    logic [31:0] pc_new;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] salt;
    logic [31:0] exp_pc;
    logic [31:0] held_ins;
    logic [31:0] prev_addr;
    logic [31:0] wrap_addrs [3];
    logic        prev_hold;
    logic        expect_empty;
    logic        rdy;
    logic        irdy;
    logic        ld;
    logic [31:0] tgt;
    int          pops;
    int          k;

    instruction_fetch #(
        .RESET_VECTOR (32'h0000_0000),
        .DEPTH        (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ins       (ins),
        .ins_pc    (ins_pc),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .pc_load   (pc_load),
        .pc_new    (pc_new)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic ir, input logic l, input logic [31:0] t);
        mem_ready = r;
        ins_ready = ir;
        pc_load   = l;
        pc_new    = t;
    endtask

    // Advance one edge, then let the memory image answer the current address.
    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = word_at(mem_addr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        salt      = $urandom;
        reset     = 1'b1;
        mem_rdata = 32'h0;
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        chk("rst_mem_req",   32'(mem_req),   32'd0);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        chk("rst_ins",       ins,            32'd0);
        chk("rst_ins_pc",    ins_pc,         32'd0);
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        tick();
        tick();

        // Streaming with memory and decoder always ready.
        reset = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("first_req",      32'(mem_req),   32'd1);
        chk("first_addr",     mem_addr,       32'd0);
        chk("first_no_valid", 32'(ins_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_valid", 32'(ins_valid), 32'd1);
            chk("stream_pc",    ins_pc,         32'(4 * i));
            chk("stream_ins",   ins,            word_at(32'(4 * i)));
        end

        // Decoder stalled: buffer fills to two entries, then fetch resumes at 8.
        do_reset();
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (5) tick();
        chk("full_req_off", 32'(mem_req),   32'd0);
        chk("full_valid",   32'(ins_valid), 32'd1);
        chk("full_head_pc", ins_pc,         32'd0);
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("resume_pc",   ins_pc,       32'd4);
        chk("resume_req",  32'(mem_req), 32'd1);
        chk("resume_addr", mem_addr,     32'd8);
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("drained_valid", 32'(ins_valid), 32'd0);
        chk("drained_addr",  mem_addr,       32'd8);

        // Redirect while the request to 0x10 is still pending.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        for (int n = 0; n < 20 && mem_addr != 32'h10; n++) tick();
        chk("reach_0x10", mem_addr, 32'h10);
        set_in(1'b0, 1'b1, 1'b1, 32'h0000_0103);
        tick();
        chk("drop_flush_valid", 32'(ins_valid), 32'd0);
        chk("drop_req_held",    32'(mem_req),   32'd1);
        chk("drop_addr_held",   mem_addr,       32'h10);
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        chk("drop_still_req", 32'(mem_req), 32'd1);
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("drop_done_req",   32'(mem_req),   32'd0);
        chk("drop_discarded",  32'(ins_valid), 32'd0);
        tick();
        chk("redir_req",  32'(mem_req), 32'd1);
        chk("redir_addr", mem_addr,     32'h100);
        tick();
        chk("redir_valid", 32'(ins_valid), 32'd1);
        chk("redir_pc",    ins_pc,         32'h100);
        chk("redir_ins",   ins,            word_at(32'h100));

        // Redirect near the top of the address space: fetch PC wraps to 0.
        set_in(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        wrap_addrs[0] = 32'hFFFF_FFF8;
        wrap_addrs[1] = 32'hFFFF_FFFC;
        wrap_addrs[2] = 32'h0000_0000;
        k = 0;
        for (int n = 0; n < 12 && k < 3; n++) begin
            if (mem_req && mem_ready) begin
                chk("wrap_addr", mem_addr, wrap_addrs[k]);
                k++;
            end
            tick();
        end
        chk("wrap_count", 32'(k), 32'd3);

        // Redirect coinciding with mem_ready while the buffer is full.
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (6) tick();
        chk("full2_req_off", 32'(mem_req),   32'd0);
        chk("full2_valid",   32'(ins_valid), 32'd1);
        held_ins = ins;
        set_in(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        tick();
        chk("full2_flushed", 32'(ins_valid), 32'd0);
        chk("full2_ins_hold", ins,           held_ins);
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("full2_req",  32'(mem_req), 32'd1);
        chk("full2_addr", mem_addr,     32'h200);

        // Asynchronous reset in the middle of an outstanding request.
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        chk("areset_pending", 32'(mem_req), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_req",   32'(mem_req),   32'd0);
        chk("areset_addr",  mem_addr,       32'd0);
        chk("areset_ins",   ins,            32'd0);
        chk("areset_pc",    ins_pc,         32'd0);
        chk("areset_valid", 32'(ins_valid), 32'd0);
        tick();
        reset = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        chk("post_rst_req",   32'(mem_req),   32'd1);
        chk("post_rst_addr",  mem_addr,       32'd0);
        chk("post_rst_stale", 32'(ins_valid), 32'd0);
        tick();
        chk("post_rst_valid", 32'(ins_valid), 32'd1);
        chk("post_rst_pc",    ins_pc,         32'd0);

        // Random traffic: decoder must see a contiguous stream from each target.
        do_reset();
        exp_pc       = 32'h0;
        pops         = 0;
        prev_hold    = 1'b0;
        prev_addr    = 32'h0;
        expect_empty = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rdy  = ($urandom_range(3) != 0);
            irdy = ($urandom_range(2) != 0);
            ld   = ($urandom_range(29) == 0);
            tgt  = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            set_in(rdy, irdy, ld, tgt);
            if (expect_empty) chk("rnd_flush_valid", 32'(ins_valid), 32'd0);
            if (prev_hold) begin
                chk("rnd_hold_req",  32'(mem_req), 32'd1);
                chk("rnd_hold_addr", mem_addr,     prev_addr);
            end
            if (mem_req) chk("rnd_align", mem_addr & 32'h3, 32'd0);
            if (ins_valid && irdy && !ld) begin
                chk("rnd_pc",  ins_pc, exp_pc);
                chk("rnd_ins", ins,    word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (ld) exp_pc = tgt & ~32'h3;
            expect_empty = ld;
            prev_hold    = mem_req && !rdy;
            prev_addr    = mem_addr;
            tick();
        end
        checks++;
        assert (pops > 200)
        else begin
            errors++;
            $error("FAIL rnd_progress: observed=%0d pops expected=more than 200", pops);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
